// File: rtl/shift_tx.sv
// Parallel-to-serial frame transmitter: captures a word on load and shifts it out
// MSB- or LSB-first, holding each bit for DIV enabled cycles.
module shift_tx #(
  parameter int SIZE = 8,
  parameter int DIV  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] din,
  input  logic            load,
  output logic            ready,
  input  logic            dir,
  input  logic            en,
  output logic            q,
  output logic            q_valid,
  output logic            busy,
  output logic            done
);

  localparam int BW = $clog2(SIZE + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t          r_state, w_state_nx;
  logic [SIZE-1:0] r_word, w_word_nx;
  logic            r_dir, w_dir_nx;
  logic [BW-1:0]   r_bit, w_bit_nx;
  logic [DW-1:0]   r_div, w_div_nx;
  logic            r_done, w_done_nx;
  logic [BW-1:0]   w_idx;
  logic [SIZE-1:0] w_mask;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_dir   <= 1'b0;
      r_bit   <= '0;
      r_div   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_word  <= w_word_nx;
      r_dir   <= w_dir_nx;
      r_bit   <= w_bit_nx;
      r_div   <= w_div_nx;
      r_done  <= w_done_nx;
    end
  end

  // Next-state logic: accept in IDLE, advance bit/divide counters in SHIFT
  always_comb begin
    w_state_nx = r_state;
    w_word_nx  = r_word;
    w_dir_nx   = r_dir;
    w_bit_nx   = r_bit;
    w_div_nx   = r_div;
    w_done_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_state_nx = S_SHIFT;
          w_word_nx  = din;
          w_dir_nx   = dir;
          w_bit_nx   = '0;
          w_div_nx   = '0;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (en) begin
          if (r_div == LAST_DIV) begin
            w_div_nx = '0;
            if (r_bit == LAST_BIT) begin
              // Last bit finished: return to IDLE and flag completion for one cycle
              w_state_nx = S_IDLE;
              w_bit_nx   = '0;
              w_done_nx  = 1'b1;
            end else begin
              w_bit_nx = r_bit + BW'(1);
            end
          end else begin
            w_div_nx = r_div + DW'(1);
          end
        end else begin
          w_state_nx = S_SHIFT;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Select the current frame bit from the captured word
  always_comb begin
    w_idx  = r_dir ? r_bit : (LAST_BIT - r_bit);
    w_mask = {{(SIZE-1){1'b0}}, 1'b1} << w_idx;
  end

  assign ready   = (r_state == S_IDLE);
  assign busy    = (r_state == S_SHIFT);
  assign q_valid = (r_state == S_SHIFT);
  assign q       = (r_state == S_SHIFT) & (|(r_word & w_mask));
  assign done    = r_done;

endmodule

// File: tb/tb_shift_tx.sv
// Self-checking bench for shift_tx: scoreboarded serial bits (DIV=1) plus a
// cycle-exact timeline check of a DIV=3 instance with an enable stall.
module tb_shift_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_load, a_dir, a_en;
  logic [7:0] a_din;
  logic       a_ready, a_q, a_qv, a_busy, a_done;
  logic       b_rst_n, b_load, b_dir, b_en;
  logic [7:0] b_din;
  logic       b_ready, b_q, b_qv, b_busy, b_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];
  logic [7:0] lb_sr;
  logic       lb_dir;

  shift_tx #(.SIZE(8), .DIV(1)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .din(a_din), .load(a_load), .ready(a_ready),
    .dir(a_dir), .en(a_en), .q(a_q), .q_valid(a_qv), .busy(a_busy), .done(a_done)
  );

  shift_tx #(.SIZE(8), .DIV(3)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .din(b_din), .load(b_load), .ready(b_ready),
    .dir(b_dir), .en(b_en), .q(b_q), .q_valid(b_qv), .busy(b_busy), .done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Receiving shift register fed by the serial stream
  always @(posedge clk) begin
    if (!a_rst_n) lb_sr <= 8'h00;
    else if (a_qv) lb_sr <= lb_dir ? {a_q, lb_sr[7:1]} : {lb_sr[6:0], a_q};
  end

  // Scoreboard: every valid bit must match the next expected bit
  always @(negedge clk) begin
    bit e;
    if (a_qv === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("q_extra", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("q_bit", {31'd0, a_q}, {31'd0, e});
      end
    end else if (a_rst_n === 1'b1) begin
      check("q_idle", {31'd0, a_q}, 32'd0);
    end
  end

  // mode 1: toggle din/dir mid-frame; mode 2: pulse load=0xFF mid-frame
  task automatic frame_a(input logic [7:0] d, input logic dr, input int mode);
    a_load = 1'b1;
    a_din  = d;
    a_dir  = dr;
    lb_dir = dr;
    check("sb_empty", exp_q.size(), 32'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back(dr ? d[i] : d[7-i]);
    step();
    a_load = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (mode == 1 && c == 4) begin
        a_dir = ~a_dir;
        a_din = ~a_din;
      end
      if (mode == 2 && c == 3) begin
        a_load = 1'b1;
        a_din  = 8'hFF;
      end
      if (mode == 2 && c == 4) a_load = 1'b0;
      @(negedge clk);
      check("busy_shift", {31'd0, a_busy}, 32'd1);
      check("ready_shift", {31'd0, a_ready}, 32'd0);
      check("qv_shift", {31'd0, a_qv}, 32'd1);
      check("done_early", {31'd0, a_done}, 32'd0);
      step();
    end
    @(negedge clk);
    check("done_pulse", {31'd0, a_done}, 32'd1);
    check("ready_done", {31'd0, a_ready}, 32'd1);
    check("busy_done", {31'd0, a_busy}, 32'd0);
    check("qv_done", {31'd0, a_qv}, 32'd0);
    check("loopback", {24'd0, lb_sr}, {24'd0, d});
  endtask

  // DIV=3 frame, en low during cycles 8 and 9 (bit 2); optionally en low at acceptance
  task automatic frame_b(input logic [7:0] d, input bit en_low_acc);
    int idx;
    b_load = 1'b1;
    b_din  = d;
    b_dir  = 1'b0;
    if (en_low_acc) b_en = 1'b0;
    step();
    b_load = 1'b0;
    b_din  = ~d;
    for (int c = 1; c <= 27; c++) begin
      b_en = (c == 8 || c == 9) ? 1'b0 : 1'b1;
      if (c <= 6) idx = (c - 1) / 3;
      else if (c <= 11) idx = 2;
      else idx = 3 + (c - 12) / 3;
      @(negedge clk);
      if (c <= 26) begin
        check("b_qv", {31'd0, b_qv}, 32'd1);
        check("b_q", {31'd0, b_q}, {31'd0, d[7-idx]});
        check("b_done_early", {31'd0, b_done}, 32'd0);
      end else begin
        check("b_done", {31'd0, b_done}, 32'd1);
        check("b_qv_done", {31'd0, b_qv}, 32'd0);
        check("b_ready_done", {31'd0, b_ready}, 32'd1);
      end
      if (c < 27) step();
    end
  endtask

  initial begin
    a_rst_n = 1'b0; a_load = 1'b0; a_dir = 1'b0; a_en = 1'b1; a_din = 8'h00;
    b_rst_n = 1'b0; b_load = 1'b0; b_dir = 1'b0; b_en = 1'b1; b_din = 8'h00;
    lb_dir = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, a_ready}, 32'd1);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_qv", {31'd0, a_qv}, 32'd0);
    check("rst_q", {31'd0, a_q}, 32'd0);
    check("rst_done", {31'd0, a_done}, 32'd0);
    check("rst_b_ready", {31'd0, b_ready}, 32'd1);
    step();
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    step();

    frame_a(8'h1E, 1'b0, 0);
    step();
    @(negedge clk);
    check("done_clear", {31'd0, a_done}, 32'd0);
    check("idle_ready", {31'd0, a_ready}, 32'd1);
    step();
    frame_a(8'h1E, 1'b1, 1);
    step();
    frame_a(8'h1E, 1'b0, 2);
    frame_a(8'hFF, 1'b0, 0);
    step();
    frame_a(8'hC3, 1'b0, 0);
    step();
    frame_a(8'h5A, 1'b1, 0);
    frame_a(8'hC3, 1'b1, 0);
    step();

    // Reset abort: reset applied during bit 4, with load held high through reset
    a_load = 1'b1; a_din = 8'h1E; a_dir = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(a_din[7-i]);
    step();
    a_load = 1'b0;
    repeat (4) step();
    a_rst_n = 1'b0;
    a_load  = 1'b1;
    a_din   = 8'hFF;
    step();
    exp_q.delete();
    @(negedge clk);
    check("abort_busy", {31'd0, a_busy}, 32'd0);
    check("abort_qv", {31'd0, a_qv}, 32'd0);
    check("abort_q", {31'd0, a_q}, 32'd0);
    check("abort_ready", {31'd0, a_ready}, 32'd1);
    check("abort_done", {31'd0, a_done}, 32'd0);
    step();
    a_rst_n = 1'b1;
    a_load  = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, a_done}, 32'd0);
      check("abort_idle", {31'd0, a_busy}, 32'd0);
      step();
    end

    frame_b(8'h80, 1'b0);
    step();
    frame_b(8'h20, 1'b1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_tx.md
SHIFT_TX -- requirements
Module: shift_tx

Interface
REQ-001 SHALL have parameter SIZE, default 8: frame width in bits (>=2).
REQ-002 SHALL have parameter DIV, default 1: enabled clock cycles per transmitted bit (>=1).
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port din  input  SIZE  parallel word to transmit.
REQ-006 SHALL have port load  input  1  request to start a frame with din.
REQ-007 SHALL have port ready  output  1  high when a load will be accepted.
REQ-008 SHALL have port dir  input  1  bit order (0 = MSB first, 1 = LSB first), sampled only at acceptance.
REQ-009 SHALL have port en  input  1  advance enable; low stalls the frame.
REQ-010 SHALL have port q  output  1  serial data bit.
REQ-011 SHALL have port q_valid  output  1  high while q carries a frame bit.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 SHALL implement two states: IDLE and SHIFT.
REQ-015 In IDLE, the block SHALL drive ready=1, busy=0, q_valid=0, and q=0.
REQ-016 Acceptance SHALL occur at an edge with load=1 and ready=1, regardless of en.
- On acceptance, din and dir SHALL be captured into internal registers.
- The state SHALL go to SHIFT with the bit counter and divide counter cleared.
REQ-017 Latency: the first bit SHALL appear on q, with q_valid=1 and busy=1, in the cycle after acceptance.
REQ-018 In SHIFT, q SHALL be the captured word bit at position:
- SIZE-1-k when captured dir=0;
- k when captured dir=1;
- where k is the bit index, 0..SIZE-1.
REQ-019 Each bit SHALL be held for exactly DIV cycles in which en=1.
- The divide counter SHALL increment only when en=1.
- On reaching DIV-1 with en=1, the divide counter SHALL clear and k SHALL increment.
REQ-020 With en=0, q, q_valid, k and the divide counter SHALL hold.
REQ-021 In SHIFT, ready SHALL be 0.
- load SHALL be ignored.
- Changes on din and dir SHALL not affect the frame in flight.
REQ-022 Completion: when bit SIZE-1 finishes its DIV-th enabled cycle, the next cycle SHALL be IDLE with done=1 for exactly one cycle.
- In that cycle, q_valid=0, busy=0 and ready=1.
REQ-023 A load in the done cycle SHALL be accepted.
- Back-to-back frames SHALL have a period of SIZE*DIV+1 cycles when en is held at 1.
REQ-024 Counter widths:
- bit counter: ceil(log2(SIZE+1)) bits;
- divide counter: max(1, ceil(log2(DIV))) bits;
- neither SHALL wrap within a frame.
REQ-025 With DIV=1, the divide counter SHALL be effectively constant and every enabled cycle SHALL advance one bit.
REQ-026 Pairing rule: with DIV=1 and en=1, feeding q into shiftreg (d=q, en=q_valid, same dir) SHALL leave the shiftreg parallel output equal to the captured din in the done cycle.

Reset
REQ-027 While rst_n=0 at an edge, the block SHALL enter IDLE.
- ready=1, busy=0, q_valid=0, q=0, done=0.
- Both counters and the captured word SHALL clear.
REQ-028 Reset during SHIFT SHALL abort the frame with no done pulse.
- load SHALL be ignored while rst_n=0.

Verification
REQ-029 Scenario: SIZE=8, DIV=1, dir=0, load din=0x1E -> q = 0,0,0,1,1,1,1,0 on cycles 1-8 after acceptance; done=1 and ready=1 on cycle 9.
REQ-030 Scenario: same as REQ-029 with dir=1 -> q = 0,1,1,1,1,0,0,0; dir toggled mid-frame has no effect.
REQ-031 Scenario: DIV=3, din=0x80, dir=0, en dropped for 2 cycles during bit 2 -> bit 0 held 3 cycles; bit 2 held 5 cycles; done on cycle 8*3+2+1=27.
REQ-032 Scenario: load with din=0xFF asserted during a 0x1E frame -> ignored, output unchanged; load 0xFF in the done cycle -> accepted, its first bit 1 appears the next cycle.
REQ-033 Scenario: rst_n=0 on the edge after bit 4 appears -> next cycle busy=0, q_valid=0, q=0, ready=1; done never pulses.
REQ-034 Scenario: loopback into shiftreg (SIZE=8, dir 0 and 1, din=0xC3 and 0x5A) -> shiftreg q equals din in the done cycle.
